// File: rtl/simmem_pkg.sv
// Shared types and defaults for the simulated-memory delay model.
package simmem_pkg;

  localparam int unsigned RespBankCapacity  = 32;
  localparam int unsigned RespBankDataWidth = 14;
  localparam int unsigned RespBankIdWidth   = 4;

  // Width of a slot index into a bank of the given capacity (at least one bit).
  function automatic int unsigned entry_idx_width(int unsigned capacity);
    return (capacity > 1) ? $clog2(capacity) : 1;
  endfunction

  // Generic bank entry shared by the write-response and read-data channels.
  typedef struct packed {
    logic [RespBankDataWidth-1:0] content;
    logic [RespBankIdWidth-1:0]   id;
  } resp_bank_entry_t;

endpackage

// File: rtl/simmem_first_one.sv
// Lowest-set-bit finder: one-hot and binary index of the lowest set input bit, plus a valid flag.
module simmem_first_one #(
  parameter int unsigned Width    = 8,
  parameter int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    in_i,
  output logic [Width-1:0]    onehot_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IdxWidth'(i);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simmem_resp_bank.sv
// ID-aware response bank: per-ID FIFO linked lists in one shared slot array, released per ID.
// Optional occupancy counter enabled by SIMMEM_RESP_BANK_OCCUPANCY_EN.
module simmem_resp_bank
  import simmem_pkg::*;
#(
  parameter int unsigned DataWidth = RespBankDataWidth,
  parameter int unsigned IDWidth   = RespBankIdWidth,
  parameter int unsigned Capacity  = RespBankCapacity,
  localparam int unsigned NumIds   = 2 ** IDWidth,
  localparam int unsigned IdxWidth = entry_idx_width(Capacity),
  localparam int unsigned LenWidth = $clog2(Capacity) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IDWidth-1:0]   in_id_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic [NumIds-1:0]    release_en_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [IDWidth-1:0]   out_id_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic [LenWidth-1:0]  occupancy_o
);

  logic [DataWidth-1:0] data_q [Capacity];
  logic [IdxWidth-1:0]  next_q [Capacity];
  logic [Capacity-1:0]  free_q;
  logic [IdxWidth-1:0]  head_q [NumIds];
  logic [IdxWidth-1:0]  tail_q [NumIds];
  logic [LenWidth-1:0]  len_q  [NumIds];
  logic [LenWidth-1:0]  len_d  [NumIds];

  logic [Capacity-1:0] alloc_onehot;
  logic [IdxWidth-1:0] alloc_idx;
  logic                alloc_valid;
  logic [NumIds-1:0]   cand;
  logic [NumIds-1:0]   sel_onehot;
  logic [IDWidth-1:0]  sel_id;
  logic                sel_valid;
  logic [NumIds-1:0]   wr_onehot;
  logic [IdxWidth-1:0] rd_slot;
  logic [Capacity-1:0] alloc_clr;
  logic [Capacity-1:0] rd_set;
  logic                wr_en;
  logic                rd_en;
  logic                wr_len_zero;
  logic                wr_head_popped;

  always_comb begin
    cand = '0;
    for (int i = 0; i < NumIds; i++) begin
      cand[i] = release_en_i[i] & (len_q[i] != '0);
    end
  end

  simmem_first_one #(
    .Width    (Capacity),
    .IdxWidth (IdxWidth)
  ) u_alloc (
    .in_i     (free_q),
    .onehot_o (alloc_onehot),
    .idx_o    (alloc_idx),
    .valid_o  (alloc_valid)
  );

  simmem_first_one #(
    .Width    (NumIds),
    .IdxWidth (IDWidth)
  ) u_sel (
    .in_i     (cand),
    .onehot_o (sel_onehot),
    .idx_o    (sel_id),
    .valid_o  (sel_valid)
  );

  assign in_ready_o  = alloc_valid;
  assign wr_en       = in_valid_i & alloc_valid;
  assign rd_en       = sel_valid & out_ready_i;
  assign rd_slot     = head_q[sel_id];
  assign out_valid_o = sel_valid;
  assign out_id_o    = sel_valid ? sel_id : '0;
  assign out_data_o  = sel_valid ? data_q[rd_slot] : '0;

  assign wr_onehot = wr_en ? (NumIds'(1) << in_id_i) : '0;
  assign alloc_clr = wr_en ? alloc_onehot : '0;
  assign rd_set    = rd_en ? (Capacity'(1) << rd_slot) : '0;

  assign wr_len_zero = (len_q[in_id_i] == '0);
  // Same-ID pop of the only entry: the new entry becomes both head and tail.
  assign wr_head_popped = rd_en && (sel_id == in_id_i) && (len_q[in_id_i] == LenWidth'(1));

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      len_d[i] = len_q[i];
      if (wr_onehot[i] && !(rd_en && sel_onehot[i])) begin
        len_d[i] = len_q[i] + LenWidth'(1);
      end else if (!wr_onehot[i] && rd_en && sel_onehot[i]) begin
        len_d[i] = len_q[i] - LenWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      free_q <= '1;
      for (int i = 0; i < NumIds; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      free_q <= (free_q & ~alloc_clr) | rd_set;
      for (int i = 0; i < NumIds; i++) begin
        len_q[i] <= len_d[i];
      end
      if (rd_en) begin
        head_q[sel_id] <= next_q[rd_slot];
      end
      // Placed after the pop so a same-ID append onto a just-emptied list takes the head.
      if (wr_en) begin
        tail_q[in_id_i] <= alloc_idx;
        if (wr_len_zero || wr_head_popped) begin
          head_q[in_id_i] <= alloc_idx;
        end
      end
    end
  end

  // Payload and link storage need no reset; validity is tracked by free_q and len_q.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      data_q[alloc_idx] <= in_data_i;
      if (!wr_len_zero) begin
        next_q[tail_q[in_id_i]] <= alloc_idx;
      end
    end
  end

`ifdef SIMMEM_RESP_BANK_OCCUPANCY_EN
  logic [LenWidth-1:0] occ_q;
  logic [LenWidth-1:0] occ_d;

  always_comb begin
    occ_d = occ_q;
    if (wr_en && !rd_en) begin
      occ_d = occ_q + LenWidth'(1);
    end else if (!wr_en && rd_en) begin
      occ_d = occ_q - LenWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = occ_q;
`else
  assign occupancy_o = '0;
`endif

endmodule

// File: tb/tb_simmem_resp_bank.sv
// Table-driven bench for simmem_resp_bank: one vector per clock cycle, outputs checked before the edge.
module tb_simmem_resp_bank;

  localparam int unsigned DataWidth = 14;
  localparam int unsigned IDWidth   = 4;
  localparam int unsigned Capacity  = 32;
  localparam int unsigned NumIds    = 16;
  localparam int unsigned OccWidth  = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [IDWidth-1:0]   in_id = '0;
  logic [DataWidth-1:0] in_data = '0;
  logic [NumIds-1:0]    release_en = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [IDWidth-1:0]   out_id;
  logic [DataWidth-1:0] out_data;
  logic [OccWidth-1:0]  occupancy;

  always #5 clk = ~clk;

  simmem_resp_bank #(
    .DataWidth (DataWidth),
    .IDWidth   (IDWidth),
    .Capacity  (Capacity)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_id_i      (in_id),
    .in_data_i    (in_data),
    .release_en_i (release_en),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_id_o     (out_id),
    .out_data_o   (out_data),
    .occupancy_o  (occupancy)
  );

  typedef struct {
    bit                   rst;
    bit                   iv;
    logic [IDWidth-1:0]   iid;
    logic [DataWidth-1:0] idata;
    logic [NumIds-1:0]    ren;
    bit                   ordy;
    bit                   ird;
    bit                   ov;
    logic [IDWidth-1:0]   oid;
    logic [DataWidth-1:0] odata;
    logic [OccWidth-1:0]  occ;
    bit                   chk;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(bit r, bit iv, int iid, int idata, int ren, bit ordy,
                              bit ird, bit ov, int oid, int odata, int occ, bit chk = 1'b1);
    vec_t v;
    v.rst   = r;
    v.iv    = iv;
    v.iid   = IDWidth'(iid);
    v.idata = DataWidth'(idata);
    v.ren   = NumIds'(ren);
    v.ordy  = ordy;
    v.ird   = ird;
    v.ov    = ov;
    v.oid   = IDWidth'(oid);
    v.odata = DataWidth'(odata);
    v.occ   = OccWidth'(occ);
    v.chk   = chk;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, got, exp);
    end
  endtask

  initial begin
    logic [OccWidth-1:0] exp_occ;

    // Idle after reset
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0));
    // Single entry held back until its ID is released
    vecs.push_back(mk(0, 1, 3, 14'h123, 16'h0000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0008, 0, 1, 1, 3, 14'h123, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0008, 1, 1, 1, 3, 14'h123, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0008, 0, 1, 0, 0, 0, 0));
    // Per-ID FIFO order, back-to-back reads
    vecs.push_back(mk(0, 1, 5, 1, 16'h0000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 2, 16'h0000, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 5, 3, 16'h0000, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0040, 1, 1, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0020, 1, 1, 1, 5, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0020, 1, 1, 1, 5, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0020, 1, 1, 1, 5, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0020, 1, 1, 0, 0, 0, 0));
    // Fixed priority: lower ID first regardless of arrival order
    vecs.push_back(mk(0, 1, 7, 14'h77, 16'h0000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 14'h22, 16'h0000, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0084, 1, 1, 1, 2, 14'h22, 2));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0084, 1, 1, 1, 7, 14'h77, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0084, 1, 1, 0, 0, 0, 0));
    // Same-ID write and read of the only entry in one cycle
    vecs.push_back(mk(0, 1, 4, 14'h11, 16'h0000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 14'h2A, 16'h0010, 1, 1, 1, 4, 14'h11, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0010, 0, 1, 1, 4, 14'h2A, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0010, 1, 1, 1, 4, 14'h2A, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0010, 1, 1, 0, 0, 0, 0));
    // Fill all slots
    for (int i = 0; i < 32; i++) begin
      vecs.push_back(mk(0, 1, i % 16, i + 100, 16'h0000, 0, 1, 0, 0, 0, i));
    end
    // Full: write refused even though a read completes this cycle
    vecs.push_back(mk(0, 1, 0, 14'h3FFF, 16'h0001, 1, 0, 1, 0, 100, 32));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0001, 1, 1, 1, 0, 116, 31));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0001, 0, 1, 0, 0, 0, 30));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0002, 0, 1, 1, 1, 101, 30));
    // Reset mid-operation discards everything
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 1'b0));
    vecs.push_back(mk(0, 0, 0, 0, 16'hFFFF, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9, 14'h55, 16'hFFFF, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'hFFFF, 1, 1, 1, 9, 14'h55, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'hFFFF, 1, 1, 0, 0, 0, 0));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < vecs.size(); k++) begin
      rst        = vecs[k].rst;
      in_valid   = vecs[k].iv;
      in_id      = vecs[k].iid;
      in_data    = vecs[k].idata;
      release_en = vecs[k].ren;
      out_ready  = vecs[k].ordy;
      #3;
      if (vecs[k].chk) begin
`ifdef SIMMEM_RESP_BANK_OCCUPANCY_EN
        exp_occ = vecs[k].occ;
`else
        exp_occ = '0;
`endif
        check("in_ready", k, 32'(in_ready), 32'(vecs[k].ird));
        check("out_valid", k, 32'(out_valid), 32'(vecs[k].ov));
        check("out_id", k, 32'(out_id), 32'(vecs[k].oid));
        check("out_data", k, 32'(out_data), 32'(vecs[k].odata));
        check("occupancy", k, 32'(occupancy), 32'(exp_occ));
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simmem_resp_bank.md
# simmem_resp_bank

Parametrised, ID-aware response bank for the simulated-memory delay model. Buffers AXI responses (write responses or read data beats) arriving from the real memory, keeps them in per-ID FIFO order inside one shared storage array, and releases the head of an ID's queue only when the delay logic enables that ID. It generalises the fixed write-response and read-data banks into one block with configurable payload width, ID width and capacity.

## Interface
Parameters:
- DataWidth, 14: payload bits per entry, excluding ID.
- IDWidth, 4: AXI ID width; NumIds = 2**IDWidth.
- Capacity, 32: total entries shared by all IDs; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset; one clock, synchronous reset, active-high.
- in_valid_i  in  1  incoming response valid.
- in_ready_o  out  1  bank can accept an entry.
- in_id_i  in  IDWidth  incoming response ID.
- in_data_i  in  DataWidth  incoming payload.
- release_en_i  in  NumIds  per-ID release permission from the delay logic.
- out_valid_o  out  1  a released entry is presented.
- out_ready_i  in  1  downstream accepts.
- out_id_o  out  IDWidth  ID of presented entry.
- out_data_o  out  DataWidth  payload of presented entry.
- occupancy_o  out  $clog2(Capacity)+1  number of stored entries.

## Operation
- State: entry array data/next[Capacity]; free bitmask[Capacity]; per-ID head, tail, len ($clog2(Capacity)+1 bits).
- Reset: all free bits 1, all len 0, head/tail 0; in_ready_o=1, out_valid_o=0, out_id_o=0, out_data_o=0, occupancy_o=0.
- Write: in_ready_o = |free. On in_valid_i & in_ready_o the lowest-index free slot is allocated, data stored, appended to tail of in_id_i (becomes head if len==0), len++.
- Read: candidate IDs = release_en_i & (len!=0). out_valid_o = |candidates; selected ID = lowest-numbered candidate (fixed priority). out_data_o = data[head[sel]]; out_id_o = sel; both 0 when out_valid_o=0.
- On out_valid_o & out_ready_i: head[sel] = next[head[sel]], len[sel]--, slot freed.
- out_valid_o may drop without handshake if release_en_i drops; no stability requirement on the output side.
- Simultaneous write and read: both performed. Same ID with len==1: new entry becomes head and tail, len stays 1. Slot freed this cycle is not allocatable until the next cycle.
- Full: in_ready_o=0 when free==0, even if a read completes that cycle.
- Per-ID order strictly FIFO; no cross-ID ordering guarantee.
- Reset mid-operation discards all stored entries.

## Timing
- Input-to-output latency: entry written at edge N is presentable from cycle N+1 (no same-cycle bypass).
- out_* is combinational from state and release_en_i; in_ready_o is combinational from state only (no path from in_valid_i or out_ready_i).
- Throughput: one write and one read per cycle.

## Configuration
- SIMMEM_RESP_BANK_OCCUPANCY_EN: defined -> occupancy_o tracks entries stored (increment on write, decrement on read, unchanged on both, max Capacity). Undefined -> counter not built, occupancy_o tied to 0.

## Structure
- simmem_pkg gains: default bank capacity, default payload/ID widths, a parametrisable entry-index width derived from capacity, and a generic bank entry struct (content plus id) used by both response channels.
- Sub-module simmem_first_one: lowest-set-bit finder (one-hot and index outputs, valid flag), instantiated for free-slot allocation and ID selection.

## Test plan
- Reset then write ID 3 data 0x123 with release_en_i=0 -> out_valid_o=0; set release_en_i[3]=1 -> out_valid_o=1, out_id_o=3, out_data_o=0x123 next cycle.
- Write ID 5 data 1,2,3, release ID 5, out_ready_i=1 -> outputs 1,2,3 in consecutive cycles, then out_valid_o=0.
- Write ID 2 and ID 7, release both -> ID 2 presented first, ID 7 next.
- Fill 32 entries -> in_ready_o=0; one read -> in_ready_o=1 following cycle; occupancy_o 32 then 31 with macro, 0 without.
- ID 4 holds one entry; same cycle read it and write ID 4 data 0x2A -> len stays 1, next output 0x2A.
- Store 10 entries, assert rst_i one cycle -> out_valid_o=0, in_ready_o=1, occupancy_o=0; releasing all IDs yields nothing.
